// File: rtl/hazard_forward_unit.sv
// Load-use stall generator and ALU operand forwarding select for a 5-stage pipeline.
// Define FWD_WB_BYPASS_EN to add a registered WB-bypass forwarding source (code 2'b11).
module hazard_forward_unit #(
  parameter int RA_W     = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] if_id_rs,
  input  logic [RA_W-1:0] if_id_rt,
  input  logic            if_id_uses_rt,
  input  logic [RA_W-1:0] id_ex_rs,
  input  logic [RA_W-1:0] id_ex_rt,
  input  logic [RA_W-1:0] id_ex_rd,
  input  logic            id_ex_mem_read,
  input  logic [RA_W-1:0] ex_mem_rd,
  input  logic            ex_mem_reg_write,
  input  logic [RA_W-1:0] mem_wb_rd,
  input  logic            mem_wb_reg_write,
  input  logic            flush,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b,
  output logic            stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int REM_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [REM_W-1:0] rem;
  logic             hazard;
  logic             exm_a, exm_b, mwb_a, mwb_b;
  logic             wb_hit_a, wb_hit_b;

  assign exm_a = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rs);
  assign exm_b = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rt);
  assign mwb_a = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs);
  assign mwb_b = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rt);

`ifdef FWD_WB_BYPASS_EN
  // Holds the write retired last cycle, for a register file without write-through.
  logic [RA_W-1:0] wb_rd;
  logic            wb_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rd    <= '0;
      wb_valid <= 1'b0;
    end else begin
      wb_rd    <= mem_wb_rd;
      wb_valid <= mem_wb_reg_write;
    end
  end

  assign wb_hit_a = !rst && wb_valid && (wb_rd != '0) && (wb_rd == id_ex_rs);
  assign wb_hit_b = !rst && wb_valid && (wb_rd != '0) && (wb_rd == id_ex_rt);
`else
  assign wb_hit_a = 1'b0;
  assign wb_hit_b = 1'b0;
`endif

  // Youngest producer wins.
  assign forward_a = exm_a ? 2'b10 : mwb_a ? 2'b01 : wb_hit_a ? 2'b11 : 2'b00;
  assign forward_b = exm_b ? 2'b10 : mwb_b ? 2'b01 : wb_hit_b ? 2'b11 : 2'b00;

  assign hazard = id_ex_mem_read && (id_ex_rd != '0) &&
                  ((id_ex_rd == if_id_rs) || (if_id_uses_rt && (id_ex_rd == if_id_rt)));

  assign stall = !rst && !flush && ((state == HOLD) || hazard);

  // The detection cycle is the first stall cycle; HOLD covers the remaining LOAD_LAT-1.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state <= HOLD;
            rem   <= REM_W'(LOAD_LAT - 2);
          end
        end
        HOLD: begin
          if (rem == '0) state <= IDLE;
          else           rem   <= rem - 1'b1;
        end
        default: begin
          state <= IDLE;
          rem   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          stall_cnt <= '0;
    else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit (LOAD_LAT=3, CNT_W=4): directed cases
// followed by random cycles checked against a cycle-count reference model.
module tb_hazard_forward_unit;

  localparam int RA_W     = 3;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef FWD_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [RA_W-1:0] if_id_rs, if_id_rt;
  logic            if_id_uses_rt;
  logic [RA_W-1:0] id_ex_rs, id_ex_rt, id_ex_rd;
  logic            id_ex_mem_read;
  logic [RA_W-1:0] ex_mem_rd;
  logic            ex_mem_reg_write;
  logic [RA_W-1:0] mem_wb_rd;
  logic            mem_wb_reg_write;
  logic            flush;
  logic [1:0]      forward_a, forward_b;
  logic            stall;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: stall cycles still owed, counter, last retired write.
  int              m_left = 0;
  int              m_cnt  = 0;
  logic [RA_W-1:0] m_wb_rd = '0;
  bit              m_wb_valid = 1'b0;
  logic            last_stall;

  hazard_forward_unit #(.RA_W(RA_W), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [RA_W-1:0] src);
    if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == src)     return 2'b10;
    if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == src)     return 2'b01;
    if (BYPASS && !rst && m_wb_valid && m_wb_rd != 0 && m_wb_rd == src) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit model_hazard();
    return id_ex_mem_read && id_ex_rd != 0 &&
           (id_ex_rd == if_id_rs || (if_id_uses_rt && id_ex_rd == if_id_rt));
  endfunction

  task automatic clearInputs();
    rst = 1'b0; flush = 1'b0;
    if_id_rs = '0; if_id_rt = '0; if_id_uses_rt = 1'b0;
    id_ex_rs = '0; id_ex_rt = '0; id_ex_rd = '0; id_ex_mem_read = 1'b0;
    ex_mem_rd = '0; ex_mem_reg_write = 1'b0;
    mem_wb_rd = '0; mem_wb_reg_write = 1'b0;
  endtask

  task automatic applyStimulus();
    if_id_rs         = RA_W'($urandom_range(0, 7));
    if_id_rt         = RA_W'($urandom_range(0, 7));
    if_id_uses_rt    = 1'($urandom_range(0, 1));
    id_ex_rs         = RA_W'($urandom_range(0, 7));
    id_ex_rt         = RA_W'($urandom_range(0, 7));
    id_ex_rd         = ($urandom_range(0, 1) == 1) ? if_id_rs : RA_W'($urandom_range(0, 7));
    id_ex_mem_read   = 1'($urandom_range(0, 1));
    ex_mem_rd        = ($urandom_range(0, 2) == 0) ? id_ex_rs : RA_W'($urandom_range(0, 7));
    ex_mem_reg_write = 1'($urandom_range(0, 1));
    mem_wb_rd        = ($urandom_range(0, 2) == 0) ? id_ex_rt : RA_W'($urandom_range(0, 7));
    mem_wb_reg_write = 1'($urandom_range(0, 1));
    flush            = ($urandom_range(0, 9) == 0);
    rst              = ($urandom_range(0, 39) == 0);
  endtask

  // One clock: check combinational outputs at negedge, advance model at posedge,
  // then check the counter just after the edge.
  task automatic runCycle(input string tag);
    logic [1:0] exp_fa, exp_fb;
    bit hz, exp_stall;
    @(negedge clk);
    hz        = model_hazard();
    exp_fa    = model_fwd(id_ex_rs);
    exp_fb    = model_fwd(id_ex_rt);
    exp_stall = !rst && !flush && (m_left > 0 || hz);
    checkOutput({tag, ".forward_a"}, 32'(forward_a), 32'(exp_fa));
    checkOutput({tag, ".forward_b"}, 32'(forward_b), 32'(exp_fb));
    checkOutput({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    last_stall = stall;
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_cnt = 0; m_wb_valid = 1'b0;
    end else begin
      if (flush)           m_left = 0;
      else if (m_left > 0) m_left--;
      else if (hz)         m_left = LOAD_LAT - 1;
      if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
      m_wb_rd    = mem_wb_rd;
      m_wb_valid = mem_wb_reg_write;
    end
    #1;
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic setLoadHazard();
    id_ex_mem_read = 1'b1; id_ex_rd = 3'd5; if_id_rs = 3'd5;
  endtask

  task automatic clearLoadHazard();
    id_ex_mem_read = 1'b0; id_ex_rd = '0; if_id_rs = '0;
  endtask

  initial begin
    int n;
    clearInputs();

    $display("[TB] reset");
    rst = 1'b1;
    runCycle("reset0");
    runCycle("reset1");
    checkOutput("reset_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    $display("[TB] forwarding priority");
    ex_mem_rd = 3'd3; ex_mem_reg_write = 1'b1; mem_wb_rd = 3'd3; mem_wb_reg_write = 1'b1; id_ex_rs = 3'd3;
    runCycle("fwd_exmem");
    checkOutput("fwd_exmem_const", 32'(forward_a), 32'd2);
    ex_mem_reg_write = 1'b0;
    runCycle("fwd_memwb");
    checkOutput("fwd_memwb_const", 32'(forward_a), 32'd1);
    clearInputs();
    ex_mem_rd = '0; ex_mem_reg_write = 1'b1; id_ex_rs = '0; id_ex_rt = '0;
    runCycle("fwd_r0");
    checkOutput("fwd_r0_a", 32'(forward_a), 32'd0);
    checkOutput("fwd_r0_b", 32'(forward_b), 32'd0);

    $display("[TB] load-use stall length");
    clearInputs();
    rst = 1'b1; runCycle("pre35_rst"); rst = 1'b0;
    setLoadHazard();
    runCycle("lu_detect");
    n = int'(last_stall);
    clearLoadHazard();
    for (int i = 0; i < 4; i++) begin
      runCycle("lu_tail");
      n += int'(last_stall);
    end
    checkOutput("lu_stall_len", 32'(n), 32'd3);
    checkOutput("lu_cnt", 32'(stall_cnt), 32'd3);

    $display("[TB] flush during stall");
    rst = 1'b1; runCycle("pre36_rst"); rst = 1'b0;
    setLoadHazard();
    runCycle("fl_detect");
    n = int'(last_stall);
    clearLoadHazard();
    flush = 1'b1;
    runCycle("fl_flush");
    checkOutput("fl_flush_stall", 32'(last_stall), 32'd0);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      runCycle("fl_after");
      n += int'(last_stall);
    end
    checkOutput("fl_stall_len", 32'(n), 32'd1);
    checkOutput("fl_cnt", 32'(stall_cnt), 32'd1);

    $display("[TB] reset mid-hold");
    setLoadHazard();
    runCycle("rh_detect");
    clearLoadHazard();
    rst = 1'b1;
    runCycle("rh_rst");
    rst = 1'b0;
    runCycle("rh_after");
    checkOutput("rh_after_stall", 32'(last_stall), 32'd0);

    $display("[TB] counter saturation");
    setLoadHazard();
    for (int i = 0; i < 20; i++) runCycle("sat_hold");
    checkOutput("sat_cnt", 32'(stall_cnt), 32'd15);
    clearLoadHazard();
    rst = 1'b1;
    runCycle("sat_rst");
    checkOutput("sat_cnt_rst", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    $display("[TB] WB bypass");
    clearInputs();
    mem_wb_rd = 3'd2; mem_wb_reg_write = 1'b1;
    runCycle("wb_write");
    mem_wb_rd = '0; mem_wb_reg_write = 1'b0; id_ex_rt = 3'd2;
    runCycle("wb_use");
    checkOutput("wb_use_b", 32'(forward_b), BYPASS ? 32'd3 : 32'd0);

    $display("[TB] random");
    for (int i = 0; i < 600; i++) begin
      applyStimulus();
      runCycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter: RA_W, default 3, register-address width in bits.
REQ-002 Parameter: LOAD_LAT, default 1, legal 1..4, stall cycles inserted per load-use hazard.
REQ-003 Parameter: CNT_W, default 16, width of the stall performance counter.
REQ-004 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Ports: if_id_rs, if_id_rt  in  RA_W  source registers of the instruction in ID.
REQ-007 Port: if_id_uses_rt  in  1  ID instruction reads rt.
REQ-008 Ports: id_ex_rs, id_ex_rt, id_ex_rd  in  RA_W  EX-stage source and destination registers.
REQ-009 Port: id_ex_mem_read  in  1  EX instruction is a load.
REQ-010 Ports: ex_mem_rd, ex_mem_reg_write  in  RA_W, 1  MEM-stage destination register and write enable.
REQ-011 Ports: mem_wb_rd, mem_wb_reg_write  in  RA_W, 1  WB-stage destination register and write enable.
REQ-012 Port: flush  in  1  branch/jump redirect from EX.
REQ-013 Ports: forward_a, forward_b  out  2  ALU operand source select for rs and rt.
REQ-014 Port: stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-015 Port: stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-016 forward_a/forward_b SHALL be combinational from current inputs: 2'b10 on EX/MEM match, else 2'b01 on MEM/WB match, else 2'b11 on WB-bypass match (REQ-031 only), else 2'b00.
REQ-017 A match SHALL require: write enable = 1, destination != 0, destination == id_ex_rs (A) or id_ex_rt (B).
REQ-018 When more than one stage matches, the youngest stage SHALL win: EX/MEM, then MEM/WB, then WB-bypass.
REQ-019 Hazard condition SHALL be: id_ex_mem_read && id_ex_rd != 0 && (id_ex_rd == if_id_rs || (if_id_uses_rt && id_ex_rd == if_id_rt)).
REQ-020 The FSM SHALL have two states, IDLE and HOLD, plus an internal down-counter rem of width ceil(log2(LOAD_LAT)), minimum 1 bit.
REQ-021 In IDLE, stall SHALL equal the hazard condition combinationally, in the same cycle.
REQ-022 On a hazard in IDLE with LOAD_LAT > 1, the FSM SHALL go to HOLD with rem = LOAD_LAT-2; with LOAD_LAT = 1 it SHALL stay in IDLE.
REQ-023 In HOLD, stall SHALL be 1 and the hazard condition SHALL be ignored; when rem = 0 the FSM SHALL return to IDLE, else rem SHALL decrement.
REQ-024 Stall latency: exactly LOAD_LAT consecutive stall cycles per hazard, starting in the detection cycle.
REQ-025 flush = 1 SHALL force stall = 0 in that cycle, move the FSM to IDLE, and clear rem; flush SHALL win over a simultaneous hazard.
REQ-026 stall_cnt SHALL increment by 1 on every cycle with stall = 1 and SHALL saturate at all-ones, with no wrap-around.
REQ-027 Forwarding SHALL remain active and unchanged during stall cycles.

Reset
REQ-028 rst = 1 at a clock edge SHALL set the FSM to IDLE, rem to 0, and stall_cnt to 0; rst SHALL take priority over flush and hazard.
REQ-029 While rst = 1, stall SHALL be 0; forward_a/forward_b SHALL follow REQ-016 with the WB-bypass register invalid.
REQ-030 rst asserted mid-HOLD SHALL abort the stall sequence; the first post-reset cycle SHALL be IDLE.

Configuration
REQ-031 When FWD_WB_BYPASS_EN is defined, a register SHALL capture mem_wb_rd and mem_wb_reg_write every cycle (valid cleared by rst) and serve as the third forwarding source, code 2'b11, covering a regfile without write-through.
REQ-032 When FWD_WB_BYPASS_EN is undefined, the register SHALL be absent and code 2'b11 SHALL never be produced.

Verification
REQ-033 ex_mem_rd=3, ex_mem_reg_write=1, mem_wb_rd=3, mem_wb_reg_write=1, id_ex_rs=3 -> forward_a=2'b10; ex_mem_reg_write=0 -> forward_a=2'b01.
REQ-034 ex_mem_rd=0, ex_mem_reg_write=1, id_ex_rs=0, id_ex_rt=0 -> forward_a=forward_b=2'b00.
REQ-035 LOAD_LAT=3: id_ex_mem_read=1, id_ex_rd=5, if_id_rs=5 for one cycle -> stall high exactly 3 cycles; stall_cnt=3.
REQ-036 LOAD_LAT=3: flush=1 in the 2nd stall cycle -> stall=0 that cycle and after; FSM in IDLE; stall_cnt=1.
REQ-037 CNT_W=4: hold the hazard for 20 stall cycles -> stall_cnt saturates at 15; then rst -> 0.
REQ-038 FWD_WB_BYPASS_EN defined: mem_wb_rd=2, mem_wb_reg_write=1 in cycle N; in cycle N+1 id_ex_rt=2 with no EX/MEM or MEM/WB match -> forward_b=2'b11.
